// File: rtl/tdm_demux_8ch_if.sv
// Bus bundle for the 8-channel TDM demultiplexer.
// sync_err exists only when TDM_SYNC_CHECK_EN is defined.
interface tdm_demux_8ch_if #(
    parameter int unsigned W = 1
);
    logic [W-1:0]   din;
    logic           din_vld;
    logic           sync;
    logic [8*W-1:0] ch_out;
    logic [8*W-1:0] frame;
    logic           frame_vld;
    logic [2:0]     slot;
    logic           locked;
`ifdef TDM_SYNC_CHECK_EN
    logic           sync_err;
`endif

    // Source of the slot-serial stream.
    modport master (
        output din, din_vld, sync,
`ifdef TDM_SYNC_CHECK_EN
        input  sync_err,
`endif
        input  ch_out, frame, frame_vld, slot, locked
    );

    // The demultiplexer itself.
    modport slave (
        input  din, din_vld, sync,
`ifdef TDM_SYNC_CHECK_EN
        output sync_err,
`endif
        output ch_out, frame, frame_vld, slot, locked
    );
endinterface

// File: rtl/tdm_demux_8ch.sv
// 1-to-8 TDM demultiplexer: routes slot-serial words into eight channel registers
// and snapshots each complete frame with a one-cycle frame_vld strobe.
// Optional macro TDM_SYNC_CHECK_EN: a missing sync at slot 0 drops lock and pulses
// sync_err; a resync mid-frame also pulses sync_err.
module tdm_demux_8ch #(
    parameter int unsigned W = 1
) (
    input logic             clk,
    input logic             rst,
    tdm_demux_8ch_if.slave  bus
);
    localparam int unsigned CW = 8 * W;

    typedef enum logic {StHunt, StLocked} state_t;

    state_t          state;
    logic [CW-1:0]   ch_q;
    logic [CW-1:0]   frame_q;
    logic [CW-1:0]   ch_next;
    logic            frame_vld_q;
    logic            locked_q;
    logic [2:0]      slot_q;
    logic [2:0]      idx;
`ifdef TDM_SYNC_CHECK_EN
    logic            sync_err_q;
`endif

    // Target slot of the current beat and the channel vector with that slot rewritten.
    always_comb begin
        idx     = bus.sync ? 3'd0 : slot_q;
        ch_next = ch_q;
        ch_next[idx*W +: W] = bus.din;
    end

    // Lock FSM, channel routing and frame snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StHunt;
            ch_q        <= '0;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            slot_q      <= 3'd0;
`ifdef TDM_SYNC_CHECK_EN
            sync_err_q  <= 1'b0;
`endif
        end else begin
            frame_vld_q <= 1'b0;
`ifdef TDM_SYNC_CHECK_EN
            sync_err_q  <= 1'b0;
`endif
            if (bus.din_vld) begin
                unique case (state)
                    StHunt: begin
                        // Only a sync beat ends the hunt; it lands in ch0 (idx is 0).
                        if (bus.sync) begin
                            ch_q     <= ch_next;
                            slot_q   <= 3'd1;
                            locked_q <= 1'b1;
                            state    <= StLocked;
                        end
                    end
                    StLocked: begin
`ifdef TDM_SYNC_CHECK_EN
                        if (!bus.sync && slot_q == 3'd0) begin
                            // Expected a frame start but sync is missing: drop lock.
                            sync_err_q <= 1'b1;
                            locked_q   <= 1'b0;
                            slot_q     <= 3'd0;
                            state      <= StHunt;
                        end else begin
                            if (bus.sync && slot_q != 3'd0) sync_err_q <= 1'b1;
                            ch_q   <= ch_next;
                            slot_q <= idx + 3'd1;
                            if (idx == 3'd7) begin
                                frame_q     <= ch_next;
                                frame_vld_q <= 1'b1;
                            end
                        end
`else
                        ch_q   <= ch_next;
                        slot_q <= idx + 3'd1;
                        // Sync forces idx to 0, so a sync beat never completes a frame.
                        if (idx == 3'd7) begin
                            frame_q     <= ch_next;
                            frame_vld_q <= 1'b1;
                        end
`endif
                    end
                    default: state <= StHunt;
                endcase
            end
        end
    end

    assign bus.ch_out    = ch_q;
    assign bus.frame     = frame_q;
    assign bus.frame_vld = frame_vld_q;
    assign bus.slot      = slot_q;
    assign bus.locked    = locked_q;
`ifdef TDM_SYNC_CHECK_EN
    assign bus.sync_err  = sync_err_q;
`endif
endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed self-checking bench for tdm_demux_8ch with W=4.
// Covers both builds (TDM_SYNC_CHECK_EN defined or not).
module tb_tdm_demux_8ch;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   vld_cnt;

    tdm_demux_8ch_if #(.W(W)) bus ();

    tdm_demux_8ch #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_vld cycles; a stretched pulse counts more than once.
    always @(posedge clk) begin
        if (bus.frame_vld === 1'b1) vld_cnt <= vld_cnt + 1;
    end

    // Hard time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // One valid beat; called at a negedge, returns at the next negedge.
    task automatic drive(input logic [W-1:0] d, input logic s);
        bus.din     = d;
        bus.din_vld = 1'b1;
        bus.sync    = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.din_vld = 1'b0;
        bus.sync    = 1'b0;
        bus.din     = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        drive(4'h3, 1'b1);
        drive(4'h4, 1'b0);
        idle(0);
        #2 rst = 1'b1;
        #2;
        checks++; if (bus.ch_out !== 32'h0) begin errors++;
            $display("FAIL rst_ch_out: got %h expected %h", bus.ch_out, 32'h0); end
        checks++; if (bus.frame !== 32'h0) begin errors++;
            $display("FAIL rst_frame: got %h expected %h", bus.frame, 32'h0); end
        checks++; if ({bus.frame_vld, bus.locked, bus.slot} !== 5'b0) begin errors++;
            $display("FAIL rst_ctrl: got %b expected %b",
                     {bus.frame_vld, bus.locked, bus.slot}, 5'b0); end
`ifdef TDM_SYNC_CHECK_EN
        checks++; if (bus.sync_err !== 1'b0) begin errors++;
            $display("FAIL rst_sync_err: got %b expected 0", bus.sync_err); end
`endif
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        drive(4'h1, 1'b0);
        drive(4'h2, 1'b0);
        drive(4'h3, 1'b0);
        idle(1);
        checks++; if (bus.locked !== 1'b0) begin errors++;
            $display("FAIL hunt_locked: got %b expected 0", bus.locked); end
        checks++; if (bus.ch_out !== 32'h0) begin errors++;
            $display("FAIL hunt_ch_out: got %h expected %h", bus.ch_out, 32'h0); end
        checks++; if (bus.slot !== 3'd0) begin errors++;
            $display("FAIL hunt_slot: got %0d expected 0", bus.slot); end
    endtask

    task automatic test_clean_frame();
        vld_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(4'(i), i == 0);
            if (i == 6) begin
                idle(0);
                checks++; if (vld_cnt !== 0) begin errors++;
                    $display("FAIL early_vld: got %0d expected 0", vld_cnt); end
            end
            if (i < 7) idle(i % 4);
        end
        checks++; if (bus.frame_vld !== 1'b1) begin errors++;
            $display("FAIL clean_vld_high: got %b expected 1", bus.frame_vld); end
        checks++; if (bus.frame !== 32'h76543210) begin errors++;
            $display("FAIL clean_frame: got %h expected %h", bus.frame, 32'h76543210); end
        checks++; if (bus.slot !== 3'd0) begin errors++;
            $display("FAIL clean_slot: got %0d expected 0", bus.slot); end
        idle(2);
        checks++; if (bus.frame_vld !== 1'b0) begin errors++;
            $display("FAIL clean_vld_low: got %b expected 0", bus.frame_vld); end
        checks++; if (vld_cnt !== 1) begin errors++;
            $display("FAIL clean_vld_cnt: got %0d expected 1", vld_cnt); end
        checks++; if (bus.locked !== 1'b1) begin errors++;
            $display("FAIL clean_locked: got %b expected 1", bus.locked); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) drive(4'(15 - i), i == 0);
        idle(2);
        checks++; if (bus.frame !== 32'h89ABCDEF) begin errors++;
            $display("FAIL b2b_frame: got %h expected %h", bus.frame, 32'h89ABCDEF); end
        checks++; if (vld_cnt !== 2) begin errors++;
            $display("FAIL b2b_vld_cnt: got %0d expected 2", vld_cnt); end
    endtask

    task automatic test_resync();
        for (int i = 0; i < 5; i++) drive(4'(i + 1), i == 0);
        drive(4'hA, 1'b1);
`ifdef TDM_SYNC_CHECK_EN
        checks++; if (bus.sync_err !== 1'b1) begin errors++;
            $display("FAIL resync_err: got %b expected 1", bus.sync_err); end
`endif
        drive(4'hB, 1'b0);
        idle(2);
        checks++; if (bus.ch_out !== 32'h89A543BA) begin errors++;
            $display("FAIL resync_ch_out: got %h expected %h", bus.ch_out, 32'h89A543BA); end
        checks++; if (bus.slot !== 3'd2) begin errors++;
            $display("FAIL resync_slot: got %0d expected 2", bus.slot); end
        checks++; if (vld_cnt !== 2) begin errors++;
            $display("FAIL resync_vld_cnt: got %0d expected 2", vld_cnt); end
        checks++; if (bus.frame !== 32'h89ABCDEF) begin errors++;
            $display("FAIL resync_frame_hold: got %h expected %h", bus.frame, 32'h89ABCDEF); end
    endtask

    task automatic test_missing_sync();
        for (int i = 0; i < 8; i++) drive(4'(i + 1), i == 0);
        idle(1);
        checks++; if (bus.frame !== 32'h87654321) begin errors++;
            $display("FAIL ms_frame: got %h expected %h", bus.frame, 32'h87654321); end
        drive(4'h5, 1'b0);
`ifdef TDM_SYNC_CHECK_EN
        checks++; if (bus.sync_err !== 1'b1) begin errors++;
            $display("FAIL ms_err_high: got %b expected 1", bus.sync_err); end
        checks++; if (bus.locked !== 1'b0) begin errors++;
            $display("FAIL ms_locked: got %b expected 0", bus.locked); end
        checks++; if (bus.ch_out !== 32'h87654321) begin errors++;
            $display("FAIL ms_ch_out: got %h expected %h", bus.ch_out, 32'h87654321); end
        checks++; if (bus.slot !== 3'd0) begin errors++;
            $display("FAIL ms_slot: got %0d expected 0", bus.slot); end
        idle(1);
        checks++; if (bus.sync_err !== 1'b0) begin errors++;
            $display("FAIL ms_err_low: got %b expected 0", bus.sync_err); end
        checks++; if (vld_cnt !== 3) begin errors++;
            $display("FAIL ms_vld_cnt: got %0d expected 3", vld_cnt); end
`else
        checks++; if (bus.ch_out !== 32'h87654325) begin errors++;
            $display("FAIL ms_ch_out: got %h expected %h", bus.ch_out, 32'h87654325); end
        checks++; if (bus.locked !== 1'b1) begin errors++;
            $display("FAIL ms_locked: got %b expected 1", bus.locked); end
        checks++; if (bus.slot !== 3'd1) begin errors++;
            $display("FAIL ms_slot: got %0d expected 1", bus.slot); end
        for (int i = 1; i < 8; i++) drive(4'(i + 5), 1'b0);
        checks++; if (bus.frame_vld !== 1'b1) begin errors++;
            $display("FAIL ms_next_vld: got %b expected 1", bus.frame_vld); end
        idle(2);
        checks++; if (bus.frame !== 32'hCBA98765) begin errors++;
            $display("FAIL ms_next_frame: got %h expected %h", bus.frame, 32'hCBA98765); end
        checks++; if (vld_cnt !== 4) begin errors++;
            $display("FAIL ms_vld_cnt: got %0d expected 4", vld_cnt); end
`endif
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        vld_cnt     = 0;
        rst         = 1'b1;
        bus.din     = '0;
        bus.din_vld = 1'b0;
        bus.sync    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(1);
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_resync();
        test_missing_sync();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
